// File: rtl/mux16_arbiter_if.sv
// rtl/mux16_arbiter_if.sv - handshake and bus bundle for the 16-bit 2:1 mux arbiter
// Purpose: groups the requester, mux-control and consumer signals of mux16_arbiter.
// Signals:
//   req_a/data_a/ack_a   requester A word offer and combinational accept
//   req_b/data_b/ack_b   requester B word offer and combinational accept
//   sel, gnt_a, gnt_b    registered mux select and grants
//   out_data/out_valid   registered selected word and its valid flag
//   out_ready            consumer accept
//   out_par              even parity of out_data (only with ARB_PARITY_EN)
// Modports: master = arbiter side, slave = producer/consumer side.
// Optional feature macro: ARB_PARITY_EN
interface mux16_arbiter_if;
   logic        req_a;
   logic [15:0] data_a;
   logic        ack_a;
   logic        req_b;
   logic [15:0] data_b;
   logic        ack_b;
   logic        sel;
   logic        gnt_a;
   logic        gnt_b;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef ARB_PARITY_EN
   logic        out_par;
`endif

   modport master (
      input  req_a, data_a, req_b, data_b, out_ready,
      output ack_a, ack_b, sel, gnt_a, gnt_b, out_data, out_valid
`ifdef ARB_PARITY_EN
      , output out_par
`endif
   );

   modport slave (
      output req_a, data_a, req_b, data_b, out_ready,
      input  ack_a, ack_b, sel, gnt_a, gnt_b, out_data, out_valid
`ifdef ARB_PARITY_EN
      , input out_par
`endif
   );
endinterface

// File: rtl/mux16_arbiter.sv
// rtl/mux16_arbiter.sv - round-robin arbiter and output register for a shared 16-bit 2:1 mux
// Purpose: grants requester A or B, drives the mux select, registers the selected word
//          and presents it to one consumer over a valid/ready handshake.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   if_bus    mux16_arbiter_if.master (requesters, select/grants, output stream)
// Parameters:
//   BURST_W    width of the burst counter
//   MAX_BURST  max consecutive transfers by one requester while the other waits (1..2^BURST_W-1)
// Optional feature macro: ARB_PARITY_EN adds registered even parity out_par.
module mux16_arbiter #(
   parameter int BURST_W   = 4,
   parameter int MAX_BURST = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mux16_arbiter_if.master   if_bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam logic [BURST_W-1:0] C_MAX  = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] C_LAST = BURST_W'(MAX_BURST - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last_b;      // 1: B won last, so A wins the next tie
   logic [BURST_W-1:0] r_count;
   logic               r_sel;
   logic [15:0]        r_out_data;
   logic               r_out_valid;
`ifdef ARB_PARITY_EN
   logic               r_out_par;
`endif

   logic               w_free;
   logic               w_ack_a;
   logic               w_ack_b;
   logic               w_gnt_a;
   logic               w_gnt_b;
   logic               w_accept;
   logic               w_other_req;
   logic               w_burst_done;
   logic [15:0]        w_word;

   // Buffer can take a word if empty or being drained this same cycle.
   assign w_free       = ~r_out_valid | if_bus.out_ready;
   assign w_accept     = w_ack_a | w_ack_b;
   assign w_word       = w_ack_b ? if_bus.data_b : if_bus.data_a;
   assign w_other_req  = (r_state == GRANT_A) ? if_bus.req_b : if_bus.req_a;
   // Burst ends on the accept that brings the count up to MAX_BURST with the other side waiting.
   assign w_burst_done = w_accept & w_other_req & (r_count >= C_LAST);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (if_bus.req_a && if_bus.req_b) begin
               w_state_nxt = r_last_b ? GRANT_A : GRANT_B;
            end else if (if_bus.req_a) begin
               w_state_nxt = GRANT_A;
            end else if (if_bus.req_b) begin
               w_state_nxt = GRANT_B;
            end
         end
         GRANT_A: begin
            if (!if_bus.req_a) begin
               w_state_nxt = if_bus.req_b ? GRANT_B : IDLE;
            end else if (w_burst_done) begin
               w_state_nxt = GRANT_B;
            end
         end
         GRANT_B: begin
            if (!if_bus.req_b) begin
               w_state_nxt = if_bus.req_a ? GRANT_A : IDLE;
            end else if (w_burst_done) begin
               w_state_nxt = GRANT_A;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: grants decode the state register, acks qualify them with request and space.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      w_ack_a = 1'b0;
      w_ack_b = 1'b0;
      case (r_state)
         GRANT_A: begin
            w_gnt_a = 1'b1;
            w_ack_a = if_bus.req_a & w_free;
         end
         GRANT_B: begin
            w_gnt_b = 1'b1;
            w_ack_b = if_bus.req_b & w_free;
         end
         default: ;
      endcase
   end

   // Arbitration bookkeeping and output buffer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_b    <= 1'b1;
         r_count     <= '0;
         r_sel       <= 1'b0;
         r_out_data  <= 16'h0000;
         r_out_valid <= 1'b0;
`ifdef ARB_PARITY_EN
         r_out_par   <= 1'b0;
`endif
      end else begin
         if ((w_state_nxt != r_state) && (w_state_nxt != IDLE)) begin
            r_last_b <= (w_state_nxt == GRANT_B);
            r_sel    <= (w_state_nxt == GRANT_B);
            r_count  <= '0;
         end else if (w_accept && w_other_req && (r_count != C_MAX)) begin
            // Only transfers made while the other side waits count against the burst.
            r_count <= r_count + 1'b1;
         end

         if (w_accept) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
`ifdef ARB_PARITY_EN
            r_out_par   <= ^w_word;
`endif
         end else if (if_bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign if_bus.ack_a     = w_ack_a;
   assign if_bus.ack_b     = w_ack_b;
   assign if_bus.gnt_a     = w_gnt_a;
   assign if_bus.gnt_b     = w_gnt_b;
   assign if_bus.sel       = r_sel;
   assign if_bus.out_data  = r_out_data;
   assign if_bus.out_valid = r_out_valid;
`ifdef ARB_PARITY_EN
   assign if_bus.out_par   = r_out_par;
`endif
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb/tb_mux16_arbiter.sv - self-checking bench for mux16_arbiter
module tb_mux16_arbiter;
   localparam int MAX = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mux16_arbiter_if bus();

   mux16_arbiter #(.BURST_W(4), .MAX_BURST(MAX)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .if_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner 0 none, 1 A, 2 B
   int          m_own;
   int          m_last;
   int          m_cnt;
   logic        m_sel;
   logic        m_val;
   logic [15:0] m_data;
   logic        m_par;
   logic        m_ack_a;
   logic        m_ack_b;

   logic        obs_ack_a;
   logic        obs_ack_b;
   logic        obs_gnt_a;
   logic        obs_gnt_b;
   logic        obs_sel;
   logic        obs_valid;
   logic [15:0] obs_data;
   logic        obs_par;

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own   = 0;
      m_last  = 2;
      m_cnt   = 0;
      m_sel   = 1'b0;
      m_val   = 1'b0;
      m_data  = 16'h0000;
      m_par   = 1'b0;
      m_ack_a = 1'b0;
      m_ack_b = 1'b0;
   endtask

   // Starts at a falling edge with inputs applied; compares, advances model over one rising edge.
   task automatic cycle();
      logic        free;
      logic        e_ack_a;
      logic        e_ack_b;
      logic        acc;
      logic        mine;
      logic        other;
      logic [15:0] word;
      int          nown;
      int          ncnt;
      #1;
      free    = !m_val || bus.out_ready;
      e_ack_a = (m_own == 1) && bus.req_a && free;
      e_ack_b = (m_own == 2) && bus.req_b && free;
      obs_ack_a = bus.ack_a;
      obs_ack_b = bus.ack_b;
      obs_gnt_a = bus.gnt_a;
      obs_gnt_b = bus.gnt_b;
      obs_sel   = bus.sel;
      obs_valid = bus.out_valid;
      obs_data  = bus.out_data;
      check1("gnt_a", obs_gnt_a, m_own == 1);
      check1("gnt_b", obs_gnt_b, m_own == 2);
      check1("sel", obs_sel, m_sel);
      check1("ack_a", obs_ack_a, e_ack_a);
      check1("ack_b", obs_ack_b, e_ack_b);
      check1("out_valid", obs_valid, m_val);
      check16("out_data", obs_data, m_data);
`ifdef ARB_PARITY_EN
      obs_par = bus.out_par;
      check1("out_par", obs_par, m_par);
`else
      obs_par = 1'b0;
`endif
      acc   = e_ack_a || e_ack_b;
      word  = e_ack_a ? bus.data_a : bus.data_b;
      mine  = (m_own == 1) ? bus.req_a : bus.req_b;
      other = (m_own == 1) ? bus.req_b : bus.req_a;
      nown  = m_own;
      ncnt  = m_cnt;
      if (m_own == 0) begin
         if (bus.req_a && bus.req_b) nown = (m_last == 1) ? 2 : 1;
         else if (bus.req_a)         nown = 1;
         else if (bus.req_b)         nown = 2;
      end else if (!mine) begin
         nown = other ? 3 - m_own : 0;
      end else if (acc && other) begin
         ncnt = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1;
         if (ncnt >= MAX) nown = 3 - m_own;
      end
      if (nown != 0 && nown != m_own) begin
         m_last = nown;
         ncnt   = 0;
         m_sel  = (nown == 2);
      end
      if (acc) begin
         m_val  = 1'b1;
         m_data = word;
         m_par  = ^word;
      end else if (bus.out_ready) begin
         m_val = 1'b0;
      end
      m_own   = nown;
      m_cnt   = ncnt;
      m_ack_a = e_ack_a;
      m_ack_b = e_ack_b;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int pre);
      #(pre);
      rst_n = 1'b0;
      #1;
      check1("rst_gnt_a", bus.gnt_a, 1'b0);
      check1("rst_gnt_b", bus.gnt_b, 1'b0);
      check1("rst_sel", bus.sel, 1'b0);
      check1("rst_valid", bus.out_valid, 1'b0);
      check16("rst_data", bus.out_data, 16'h0000);
      check1("rst_ack_a", bus.ack_a, 1'b0);
      check1("rst_ack_b", bus.ack_b, 1'b0);
`ifdef ARB_PARITY_EN
      check1("rst_par", bus.out_par, 1'b0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Replace the word of whichever requester was just accepted.
   task automatic new_words();
      if (m_ack_a) bus.data_a = 16'($urandom);
      if (m_ack_b) bus.data_b = 16'($urandom);
   endtask

   task automatic drive_rand();
      if (bus.req_a && !m_ack_a) begin
         if ($urandom_range(0, 9) == 0) bus.req_a = 1'b0;
      end else begin
         bus.req_a  = ($urandom_range(0, 3) != 0);
         bus.data_a = 16'($urandom);
      end
      if (bus.req_b && !m_ack_b) begin
         if ($urandom_range(0, 9) == 0) bus.req_b = 1'b0;
      end else begin
         bus.req_b  = ($urandom_range(0, 3) != 0);
         bus.data_b = 16'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
   endtask

   initial begin
      int          good;
      int          acks;
      int          gnts;
      logic [15:0] hold;
      n_checks = 0;
      n_fail   = 0;
      rst_n         = 1'b0;
      bus.req_a     = 1'b0;
      bus.req_b     = 1'b0;
      bus.data_a    = 16'h0000;
      bus.data_b    = 16'h0000;
      bus.out_ready = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset(0);

      // Single requester A
      bus.req_a  = 1'b1;
      bus.data_a = 16'h1234;
      cycle();
      check1("single_c1_ack", obs_ack_a, 1'b0);
      cycle();
      check1("single_c2_ack", obs_ack_a, 1'b1);
      bus.req_a = 1'b0;
      cycle();
      check16("single_c3_data", obs_data, 16'h1234);
      check1("single_c3_valid", obs_valid, 1'b1);
      check1("single_c3_sel", obs_sel, 1'b0);
      cycle();

      // Fairness: both requesting, 8/8 alternation with no idle cycle
      do_reset(0);
      bus.req_a     = 1'b1;
      bus.req_b     = 1'b1;
      bus.data_a    = 16'($urandom);
      bus.data_b    = 16'($urandom);
      bus.out_ready = 1'b1;
      cycle();
      good = 0;
      for (int k = 0; k < 32; k++) begin
         cycle();
         new_words();
         if (((k / 8) % 2 == 0) ? (obs_ack_a && !obs_ack_b && !obs_sel)
                                : (obs_ack_b && !obs_ack_a && obs_sel)) good++;
      end
      check16("fair_pattern", 16'(good), 16'd32);

      // Reset mid-transfer with a word pending, then first tie goes to A
      do_reset(3);
      cycle();
      cycle();
      check1("post_reset_tie_a", obs_gnt_a, 1'b1);
      check1("post_reset_ack_a", obs_ack_a, 1'b1);
      new_words();

      // Backpressure
      for (int k = 0; k < 3; k++) begin
         cycle();
         new_words();
      end
      bus.out_ready = 1'b0;
      hold = m_data;
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check16("bp_data_hold", obs_data, hold);
         if (obs_ack_a || obs_ack_b) acks++;
      end
      check16("bp_no_ack", 16'(acks), 16'd0);
      bus.out_ready = 1'b1;
      cycle();
      check1("bp_release_ack", obs_ack_a | obs_ack_b, 1'b1);
      new_words();

      // Lone burst from B
      bus.req_a = 1'b0;
      for (int k = 0; k < 4 && m_own != 2; k++) begin
         cycle();
         new_words();
      end
      acks = 0;
      gnts = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (obs_ack_b) acks++;
         if (obs_gnt_b) gnts++;
         bus.data_b = 16'($urandom);
      end
      check16("lone_acks", 16'(acks), 16'd20);
      check16("lone_gnts", 16'(gnts), 16'd20);
      bus.req_b = 1'b0;
      cycle();
      cycle();
      check1("lone_idle_gnt_b", obs_gnt_b, 1'b0);
      check1("lone_idle_sel", obs_sel, 1'b1);

`ifdef ARB_PARITY_EN
      bus.req_a  = 1'b1;
      bus.data_a = 16'h0007;
      cycle();
      cycle();
      bus.req_a = 1'b0;
      cycle();
      check1("par_0007", obs_par, 1'b1);
      bus.req_a  = 1'b1;
      bus.data_a = 16'h0003;
      cycle();
      cycle();
      bus.req_a = 1'b0;
      cycle();
      check1("par_0003", obs_par, 1'b0);
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         drive_rand();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
